// File: rtl/hazard3_eth_rxq_ctrl_pkg.sv
// rtl/hazard3_eth_rxq_ctrl_pkg.sv - shared types and constants for the Ethernet RX queue
package hazard3_eth_rxq_ctrl_pkg;

    localparam int ETH_MTU = 1536;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } rxq_state_t;

    function automatic int slot_base(input int slot, input int mtu);
        return slot * mtu;
    endfunction

endpackage

// File: rtl/hazard3_eth_rxq_desc.sv
// rtl/hazard3_eth_rxq_desc.sv - length FIFO of committed frames with simultaneous push/pop
module hazard3_eth_rxq_desc #(
    parameter int N_SLOTS = 4,
    parameter int LW      = 16,
    localparam int SW     = $clog2(N_SLOTS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [LW-1:0] push_len,
    input  logic          pop,
    output logic [SW-1:0] wr_ptr,
    output logic [SW-1:0] rd_ptr,
    output logic [SW:0]   count,
    output logic [LW-1:0] head_len
);

    logic [LW-1:0] len_q [N_SLOTS];
    logic          pop_ok;

    // Pops on an empty queue are ignored; the controller never pushes when full.
    assign pop_ok   = pop && (count != '0);
    assign head_len = len_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < N_SLOTS; i++) len_q[i] <= '0;
        end else begin
            if (push) begin
                len_q[wr_ptr] <= push_len;
                wr_ptr        <= wr_ptr + SW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + SW'(1);
            case ({push, pop_ok})
                2'b10:   count <= count + (SW+1)'(1);
                2'b01:   count <= count - (SW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hazard3_eth_rxq_ctrl.sv
// rtl/hazard3_eth_rxq_ctrl.sv - MAC RX byte stream into slotted frame buffer with descriptor queue
module hazard3_eth_rxq_ctrl
    import hazard3_eth_rxq_ctrl_pkg::*;
#(
    parameter int MTU     = ETH_MTU,
    parameter int N_SLOTS = 4,
    parameter int AW      = 13,
    parameter int LW      = 16,
    localparam int SW     = $clog2(N_SLOTS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rx_last,
    input  logic          rx_err,
    output logic          buf_we,
    output logic [AW-1:0] buf_waddr,
    output logic [7:0]    buf_wdata,
    input  logic          host_pop,
    output logic          frame_avail,
    output logic [SW-1:0] frame_slot,
    output logic [AW-1:0] frame_base,
    output logic [LW-1:0] frame_len,
    output logic [SW:0]   q_count,
    output logic [15:0]   drop_cnt,
    output logic          drop_pulse
);

    rxq_state_t    state, nxt_state;
    logic [LW-1:0] wcnt;
    logic [LW-1:0] wr_off;
    logic [LW-1:0] push_len;
    logic [SW-1:0] wr_ptr;
    logic          wr_en, push, drop, full;

    hazard3_eth_rxq_desc #(.N_SLOTS(N_SLOTS), .LW(LW)) u_desc (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_len (push_len),
        .pop      (host_pop),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (frame_slot),
        .count    (q_count),
        .head_len (frame_len)
    );

    assign full        = (q_count == (SW+1)'(N_SLOTS));
    assign frame_avail = (q_count != '0);
    assign frame_base  = AW'(slot_base(int'(frame_slot), MTU));

    always_comb begin
        nxt_state = state;
        wr_en     = 1'b0;
        wr_off    = wcnt;
        push      = 1'b0;
        drop      = 1'b0;
        push_len  = '0;
        case (state)
            IDLE: if (rx_valid) begin
                if (full) begin
                    drop      = rx_last;
                    nxt_state = rx_last ? IDLE : DISCARD;
                end else begin
                    wr_en  = 1'b1;
                    wr_off = '0;
                    if (rx_last) begin
                        drop     = rx_err;
                        push     = !rx_err;
                        push_len = LW'(1);
                    end else begin
                        nxt_state = RECV;
                    end
                end
            end
            RECV: if (rx_valid) begin
                if (wcnt < LW'(MTU)) begin
                    wr_en = 1'b1;
                    if (rx_last) begin
                        drop      = rx_err;
                        push      = !rx_err;
                        push_len  = wcnt + LW'(1);
                        nxt_state = IDLE;
                    end
                end else begin
                    // Byte MTU+1: the frame is oversized and can never commit.
                    drop      = rx_last;
                    nxt_state = rx_last ? IDLE : DISCARD;
                end
            end
            DISCARD: if (rx_valid && rx_last) begin
                drop      = 1'b1;
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wcnt       <= '0;
            buf_we     <= 1'b0;
            buf_waddr  <= '0;
            buf_wdata  <= '0;
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            state      <= nxt_state;
            buf_we     <= wr_en;
            drop_pulse <= drop;
            if (wr_en) begin
                wcnt      <= wr_off + LW'(1);
                buf_waddr <= AW'(slot_base(int'(wr_ptr), MTU) + int'(wr_off));
                buf_wdata <= rx_data;
            end
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard3_eth_rxq_ctrl.sv
// tb/tb_hazard3_eth_rxq_ctrl.sv - directed self-checking bench for hazard3_eth_rxq_ctrl
module tb_hazard3_eth_rxq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_last = 1'b0;
    logic        rx_err = 1'b0;
    logic        host_pop = 1'b0;
    logic        buf_we;
    logic [12:0] buf_waddr;
    logic [7:0]  buf_wdata;
    logic        frame_avail;
    logic [1:0]  frame_slot;
    logic [12:0] frame_base;
    logic [15:0] frame_len;
    logic [2:0]  q_count;
    logic [15:0] drop_cnt;
    logic        drop_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_base = 0;
    int exp_seed = 0;
    int wr_idx   = 0;
    int wr_bad   = 0;
    int pulse_cnt = 0;

    hazard3_eth_rxq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_last     (rx_last),
        .rx_err      (rx_err),
        .buf_we      (buf_we),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .host_pop    (host_pop),
        .frame_avail (frame_avail),
        .frame_slot  (frame_slot),
        .frame_base  (frame_base),
        .frame_len   (frame_len),
        .q_count     (q_count),
        .drop_cnt    (drop_cnt),
        .drop_pulse  (drop_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (buf_we) begin
            if (buf_waddr != 13'(exp_base + wr_idx) || buf_wdata != 8'(exp_seed + wr_idx))
                wr_bad++;
            wr_idx++;
        end
        if (drop_pulse) pulse_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; host_pop = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic expect_writes(input int base, input int seed);
        exp_base = base;
        exp_seed = seed;
        wr_idx   = 0;
        wr_bad   = 0;
    endtask

    task automatic send_frame(input int n, input bit err, input int seed, input bit pop_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b1;
            rx_data  = 8'(seed + i);
            rx_last  = (i == n - 1);
            rx_err   = err && (i == n - 1);
            host_pop = pop_last && (i == n - 1);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; host_pop = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_frame();
        @(posedge clk);
        #1 host_pop = 1'b1;
        @(posedge clk);
        #1 host_pop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        check_eq("rst_outs", 32'({buf_we, buf_waddr, buf_wdata, frame_avail, drop_pulse}), 32'd0);
        check_eq("rst_head", 32'({frame_slot, frame_base, frame_len}), 32'd0);
        check_eq("rst_cnts", 32'({q_count, drop_cnt}), 32'd0);

        // 64-byte frame into slot 0
        expect_writes(0, 0);
        send_frame(64, 1'b0, 0, 1'b0);
        check_eq("f64_writes", 32'(wr_idx), 32'd64);
        check_eq("f64_bad", 32'(wr_bad), 32'd0);
        check_eq("f64_avail", 32'(frame_avail), 32'd1);
        check_eq("f64_slot", 32'(frame_slot), 32'd0);
        check_eq("f64_len", 32'(frame_len), 32'd64);
        check_eq("f64_q", 32'(q_count), 32'd1);

        // five 100-byte frames, fifth finds the queue full
        do_reset();
        for (int k = 0; k < 5; k++) begin
            expect_writes(k * 1536, k * 16);
            send_frame(100, 1'b0, k * 16, 1'b0);
            check_eq($sformatf("fill%0d_writes", k), 32'(wr_idx), (k < 4) ? 32'd100 : 32'd0);
            check_eq($sformatf("fill%0d_bad", k), 32'(wr_bad), 32'd0);
        end
        check_eq("full_q", 32'(q_count), 32'd4);
        check_eq("full_drop", 32'(drop_cnt), 32'd1);
        check_eq("full_pulse", 32'(pulse_cnt), 32'd1);
        check_eq("full_base", 32'(frame_base), 32'd0);
        check_eq("full_len", 32'(frame_len), 32'd100);
        pop_frame();
        check_eq("pop1_slot", 32'(frame_slot), 32'd1);
        check_eq("pop1_base", 32'(frame_base), 32'd1536);
        check_eq("pop1_q", 32'(q_count), 32'd3);

        // oversized frame then a normal frame in the same slot
        do_reset();
        pulse_cnt = 0;
        expect_writes(0, 7);
        send_frame(1600, 1'b0, 7, 1'b0);
        check_eq("big_writes", 32'(wr_idx), 32'd1536);
        check_eq("big_bad", 32'(wr_bad), 32'd0);
        check_eq("big_drop", 32'(drop_cnt), 32'd1);
        check_eq("big_pulse", 32'(pulse_cnt), 32'd1);
        check_eq("big_q", 32'(q_count), 32'd0);
        expect_writes(0, 33);
        send_frame(60, 1'b0, 33, 1'b0);
        check_eq("after_big_writes", 32'(wr_idx), 32'd60);
        check_eq("after_big_bad", 32'(wr_bad), 32'd0);
        check_eq("after_big_head", 32'({frame_avail, frame_slot, frame_len}), 32'({1'b1, 2'd0, 16'd60}));

        // errored frame, then good frame, then 1-byte frame
        do_reset();
        expect_writes(0, 1);
        send_frame(60, 1'b1, 1, 1'b0);
        check_eq("err_drop", 32'(drop_cnt), 32'd1);
        check_eq("err_avail", 32'(frame_avail), 32'd0);
        expect_writes(0, 2);
        send_frame(60, 1'b0, 2, 1'b0);
        check_eq("good_bad", 32'(wr_bad), 32'd0);
        check_eq("good_head", 32'({frame_slot, frame_len, q_count}), 32'({2'd0, 16'd60, 3'd1}));
        expect_writes(1536, 9);
        send_frame(1, 1'b0, 9, 1'b0);
        check_eq("one_writes", 32'(wr_idx), 32'd1);
        check_eq("one_bad", 32'(wr_bad), 32'd0);
        check_eq("one_q", 32'(q_count), 32'd2);
        pop_frame();
        check_eq("one_head", 32'({frame_slot, frame_len}), 32'({2'd1, 16'd1}));

        // pop coincident with commit, then pop on empty queue
        do_reset();
        expect_writes(0, 0);
        send_frame(10, 1'b0, 0, 1'b0);
        expect_writes(1536, 0);
        send_frame(20, 1'b0, 0, 1'b1);
        check_eq("cp_q", 32'(q_count), 32'd1);
        check_eq("cp_slot", 32'(frame_slot), 32'd1);
        check_eq("cp_len", 32'(frame_len), 32'd20);
        pop_frame();
        check_eq("cp_pop_q", 32'(q_count), 32'd0);
        pop_frame();
        check_eq("empty_pop_q", 32'(q_count), 32'd0);
        check_eq("empty_pop_slot", 32'(frame_slot), 32'd2);

        // reset in the middle of a frame
        expect_writes(0, 0);
        send_frame(5, 1'b1, 0, 1'b0);
        check_eq("pre_rst_drop", 32'(drop_cnt), 32'd1);
        expect_writes(3072, 8'h50);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b1;
            rx_data  = 8'(8'h50 + i);
        end
        @(posedge clk);
        #1;
        check_eq("mid_we", 32'(buf_we), 32'd1);
        check_eq("mid_addr", 32'(buf_waddr), 32'd3101);
        #1 rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        check_eq("arst_outs", 32'({buf_we, buf_waddr, buf_wdata, drop_pulse}), 32'd0);
        check_eq("arst_cnts", 32'({q_count, drop_cnt, frame_slot}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expect_writes(0, 8'h80);
        send_frame(40, 1'b0, 8'h80, 1'b0);
        check_eq("post_rst_writes", 32'(wr_idx), 32'd40);
        check_eq("post_rst_bad", 32'(wr_bad), 32'd0);
        check_eq("post_rst_head", 32'({frame_slot, frame_len, q_count}), 32'({2'd0, 16'd40, 3'd1}));
        check_eq("post_rst_drop", 32'(drop_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard3_eth_rxq_ctrl.md
Name: hazard3_eth_rxq_ctrl

Overview:
- Receive-queue controller between the Ethernet MAC receive byte stream and the shared RX frame buffer RAM.
- Slices the RAM into N_SLOTS fixed MTU-sized slots and writes each incoming frame into the next free slot.
- Commits frame lengths into a FIFO of descriptors, drops frames when the queue is full, oversized or errored.
- Lets the APB-side driver consume frames in order: read length and slot, read bytes from the RAM, then pop.

Parameters:
- MTU, 1536, slot size in bytes; maximum accepted frame length.
- N_SLOTS, 4, number of frame slots; power of two, at least 2.
- AW, 13, buffer byte-address width; must satisfy 2**AW >= N_SLOTS*MTU.
- LW, 16, frame-length field width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  MAC byte strobe, one byte per cycle when high; no backpressure
- rx_data  in  8  received byte
- rx_last  in  1  marks final byte of frame (qualified by rx_valid)
- rx_err  in  1  frame bad (FCS/PHY error); sampled with rx_last
- buf_we  out  1  RAM byte write enable
- buf_waddr  out  AW  RAM byte address = slot*MTU + offset
- buf_wdata  out  8  RAM write data
- host_pop  in  1  single-cycle pulse: release head frame
- frame_avail  out  1  at least one committed frame queued
- frame_slot  out  log2(N_SLOTS)  slot index of head frame
- frame_base  out  AW  head slot base address (frame_slot*MTU)
- frame_len  out  LW  byte length of head frame
- q_count  out  log2(N_SLOTS)+1  committed frames queued
- drop_cnt  out  16  dropped-frame counter, saturates at 16'hFFFF
- drop_pulse  out  1  one-cycle pulse per dropped frame

Behaviour:
- Reset: all outputs 0, state IDLE, wr_ptr = rd_ptr = 0, q_count 0, len array cleared. Reset mid-frame discards the partial frame with no drop count.
- buf_we/buf_waddr/buf_wdata are registered: write occurs one cycle after the byte is accepted.
- FSM IDLE, RECV, DISCARD.
  - IDLE, rx_valid high, q_count == N_SLOTS: frame is dropped. If rx_last, stay IDLE and drop now; else go to DISCARD.
  - IDLE, rx_valid high, slot free: write byte at offset 0 of wr_ptr slot, wcnt := 1. If rx_last, commit (length 1) or drop per rx_err; else go to RECV.
  - RECV, rx_valid high, wcnt < MTU: write byte at offset wcnt, wcnt++.
  - RECV, rx_valid high, wcnt == MTU (byte MTU+1 arrives): no write. If not rx_last go to DISCARD; else drop and go to IDLE.
  - RECV, rx_last: if rx_err or oversized, drop; else commit length wcnt+1. Go to IDLE.
  - DISCARD: ignore bytes. On rx_valid & rx_last, drop (single drop per frame) and go to IDLE.
- Commit: len[wr_ptr] := length; wr_ptr := wr_ptr+1 mod N_SLOTS; q_count++. Frame_avail and head fields update the cycle after the last byte's edge. Commit never occurs before that frame's final buf_we.
- Drop: drop_cnt++ (saturating), drop_pulse for one cycle. The slot is not consumed; wr_ptr is unchanged.
- Pop: if host_pop and q_count > 0, rd_ptr++ mod N_SLOTS and q_count--. Pop with q_count == 0 is ignored.
- Commit and pop in the same cycle: q_count unchanged, both pointers advance.
- frame_slot = rd_ptr, frame_len = len[rd_ptr], frame_base = rd_ptr*MTU. These are valid only while frame_avail is high and stay stable until a pop.
- The slot being filled is never the head slot while q_count < N_SLOTS, so host reads and MAC writes are race-free.

Decomposition:
- Shared package holds ETH_MTU (same value as the rest of the Ethernet subsystem), the FSM state typedef (IDLE/RECV/DISCARD), and a slot-base helper constant function.
- One natural sub-module: hazard3_eth_rxq_desc, the N_SLOTS-deep length FIFO with pointers, count, and simultaneous push/pop.

Test Plan:
- 64-byte frame 0x00..0x3F, rx_err=0 -> 64 writes at addresses 0..63 with matching data; frame_avail=1, frame_slot=0, frame_len=64, q_count=1.
- 5 back-to-back 100-byte frames, no pops -> slots 0..3 fill at bases 0,1536,3072,4608; 5th frame produces no buf_we, drop_cnt=1, q_count=4.
- 1600-byte frame -> exactly 1536 writes, then drop at the last byte; drop_cnt +1, q_count unchanged, following 60-byte frame lands in the same slot.
- 60-byte frame with rx_err on last byte -> drop_cnt +1, frame_avail stays 0; next good 60-byte frame commits in slot 0.
- q_count=1; host_pop in the same cycle a new frame commits -> q_count stays 1, frame_slot advances to 1; host_pop at q_count=0 -> no change.
- Assert rst_n low mid-frame (byte 30) -> all outputs 0 immediately; next frame written from slot 0 offset 0, drop_cnt=0.
